// File: rtl/axis_rr_pkt_sched.sv
// Packet-level round-robin scheduler for four AXI-Stream FIFOs feeding a 4:1 mux.
// One input is locked from its first beat through tlast (or a forced release at
// MAX_BEATS), so packets never interleave on the muxed bus.
`timescale 1ns/1ps
module axis_rr_pkt_sched #(
    parameter logic [7:0]  SEL_BASE  = 8'd128,
    parameter logic [15:0] MAX_BEATS = 16'd1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sched_en,
    input  logic       axis_in_0_tvalid,
    input  logic       axis_in_1_tvalid,
    input  logic       axis_in_2_tvalid,
    input  logic       axis_in_3_tvalid,
    input  logic       axis_in_0_tlast,
    input  logic       axis_in_1_tlast,
    input  logic       axis_in_2_tlast,
    input  logic       axis_in_3_tlast,
    input  logic       axis_out_tready,
    output logic       axis_in_0_tready,
    output logic       axis_in_1_tready,
    output logic       axis_in_2_tready,
    output logic       axis_in_3_tready,
    output logic [7:0] bus_sel,
    output logic       pkt_done,
    output logic [1:0] pkt_src,
    output logic       err_oversize
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant, grant_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [15:0] beat_cnt, beat_cnt_nxt;
    logic [7:0]  bus_sel_nxt;
    logic        pkt_done_nxt;
    logic [1:0]  pkt_src_nxt;
    logic        err_nxt;

    logic [3:0]  tvalid, tlast, tready;
    logic [1:0]  pick;
    logic        pick_vld;
    logic        beat, last_g, at_limit;

    assign tvalid = {axis_in_3_tvalid, axis_in_2_tvalid, axis_in_1_tvalid, axis_in_0_tvalid};
    assign tlast  = {axis_in_3_tlast,  axis_in_2_tlast,  axis_in_1_tlast,  axis_in_0_tlast};

    assign axis_in_0_tready = tready[0];
    assign axis_in_1_tready = tready[1];
    assign axis_in_2_tready = tready[2];
    assign axis_in_3_tready = tready[3];

    assign last_g   = tlast[grant];
    assign beat     = (state == BUSY) && tvalid[grant] && axis_out_tready;
    // Beat that fills the packet to MAX_BEATS; a tlast on that same beat wins.
    assign at_limit = (beat_cnt == MAX_BEATS - 16'd1);

    // Round-robin pick: scan from ptr downwards in priority so the nearest valid wins.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (tvalid[ptr + 2'(i)]) begin
                pick     = ptr + 2'(i);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state, release handling and ready steering.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        ptr_nxt      = ptr;
        beat_cnt_nxt = beat_cnt;
        pkt_done_nxt = 1'b0;
        pkt_src_nxt  = pkt_src;
        err_nxt      = err_oversize;
        tready       = 4'b0000;
        case (state)
            IDLE: begin
                if (sched_en && pick_vld) begin
                    state_nxt    = BUSY;
                    grant_nxt    = pick;
                    beat_cnt_nxt = 16'd0;
                end
            end
            BUSY: begin
                tready[grant] = axis_out_tready;
                if (beat) begin
                    if (last_g || at_limit) begin
                        state_nxt    = IDLE;
                        ptr_nxt      = grant + 2'd1;
                        pkt_done_nxt = 1'b1;
                        pkt_src_nxt  = grant;
                        if (!last_g) begin
                            err_nxt = 1'b1;
                        end
                    end else if (beat_cnt != 16'hFFFF) begin
                        beat_cnt_nxt = beat_cnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        bus_sel_nxt = (state_nxt == BUSY) ? (SEL_BASE + {6'd0, grant_nxt}) : 8'd0;
    end

    // State and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= 2'd0;
            ptr          <= 2'd0;
            beat_cnt     <= 16'd0;
            bus_sel      <= 8'd0;
            pkt_done     <= 1'b0;
            pkt_src      <= 2'd0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_nxt;
            grant        <= grant_nxt;
            ptr          <= ptr_nxt;
            beat_cnt     <= beat_cnt_nxt;
            bus_sel      <= bus_sel_nxt;
            pkt_done     <= pkt_done_nxt;
            pkt_src      <= pkt_src_nxt;
            err_oversize <= err_nxt;
        end
    end

endmodule

// File: tb/tb_axis_rr_pkt_sched.sv
// Bench for axis_rr_pkt_sched: directed scenarios plus random traffic, all
// checked every cycle against a packet-level reference model.
`timescale 1ns/1ps
module tb_axis_rr_pkt_sched;

    localparam logic [15:0] MAXB = 16'd4;

    logic       clk = 1'b0;
    logic       rst_n, sched_en, out_rdy;
    logic [3:0] tv, tl;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic [7:0] bus_sel;
    logic       pkt_done, err_oversize;
    logic [1:0] pkt_src;

    always #5 clk = ~clk;

    axis_rr_pkt_sched #(.SEL_BASE(8'd128), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst_n(rst_n), .sched_en(sched_en),
        .axis_in_0_tvalid(tv[0]), .axis_in_1_tvalid(tv[1]),
        .axis_in_2_tvalid(tv[2]), .axis_in_3_tvalid(tv[3]),
        .axis_in_0_tlast(tl[0]), .axis_in_1_tlast(tl[1]),
        .axis_in_2_tlast(tl[2]), .axis_in_3_tlast(tl[3]),
        .axis_out_tready(out_rdy),
        .axis_in_0_tready(rdy0), .axis_in_1_tready(rdy1),
        .axis_in_2_tready(rdy2), .axis_in_3_tready(rdy3),
        .bus_sel(bus_sel), .pkt_done(pkt_done), .pkt_src(pkt_src),
        .err_oversize(err_oversize)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: which input owns the bus (-1 = none), who is next in line,
    // and how many beats the current packet has delivered.
    int m_owner, m_ptr, m_cnt, m_src;
    bit m_done, m_err;

    // Traffic sources: each input has at most one packet pending.
    bit act[4];
    int len[4], sent[4];
    bit refill;
    int refill_len;

    // Observations of the DUT for scenario-level checks.
    logic [7:0] prev_sel;
    logic [7:0] grants[$];
    int n82, done0;

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_src = 0; m_done = 0; m_err = 0;
    endtask

    task automatic start(input int n, input int l);
        act[n] = 1; len[n] = l; sent[n] = 0;
    endtask

    task automatic cycle(input bit r_n, input bit en, input bit rdy);
        logic [3:0] v, l, exp_rdy, got_rdy;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            v[n] = act[n];
            l[n] = act[n] && (sent[n] == len[n] - 1);
        end
        tv = v; tl = l; rst_n = r_n; sched_en = en; out_rdy = rdy;
        #1;
        exp_rdy = 4'b0000;
        if (m_owner >= 0) exp_rdy[m_owner] = rdy;
        got_rdy = {rdy3, rdy2, rdy1, rdy0};
        check_eq("bus_sel", {24'd0, bus_sel}, (m_owner < 0) ? 32'd0 : 32'(128 + m_owner));
        check_eq("tready", {28'd0, got_rdy}, {28'd0, exp_rdy});
        check_eq("pkt_done", {31'd0, pkt_done}, {31'd0, m_done});
        check_eq("err_oversize", {31'd0, err_oversize}, {31'd0, m_err});
        if (m_done) check_eq("pkt_src", {30'd0, pkt_src}, 32'(m_src));
        if (bus_sel != 8'd0 && prev_sel == 8'd0) grants.push_back(bus_sel);
        prev_sel = bus_sel;
        if (bus_sel == 8'h82) n82++;
        if (pkt_done && pkt_src == 2'd0) done0++;
        // Advance the model across the coming clock edge.
        if (!r_n) begin
            model_reset();
        end else begin
            m_done = 0;
            if (m_owner < 0) begin
                if (en && v != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (v[(m_ptr + k) % 4]) begin
                            m_owner = (m_ptr + k) % 4;
                            break;
                        end
                    end
                    m_cnt = 0;
                end
            end else if (v[m_owner] && rdy) begin
                int o;
                o = m_owner;
                m_cnt++;
                sent[o]++;
                if (l[o] || m_cnt == int'(MAXB)) begin
                    m_done = 1;
                    m_src = o;
                    if (!l[o]) m_err = 1;
                    m_ptr = (o + 1) % 4;
                    m_owner = -1;
                end
                if (l[o]) begin
                    act[o] = 0;
                    if (refill) start(o, refill_len);
                end
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin act[n] = 0; len[n] = 1; sent[n] = 0; end
        refill = 0; refill_len = 2; prev_sel = 8'd0; n82 = 0; done0 = 0;
        rst_n = 1'b0; sched_en = 1'b0; out_rdy = 1'b0; tv = 4'b0; tl = 4'b0;
        repeat (2) @(posedge clk);
        model_reset();
        // Reset state held.
        cycle(0, 1, 1);

        // Single input, 3-beat packet.
        start(2, 3);
        n82 = 0;
        repeat (6) cycle(1, 1, 1);
        check_eq("single_sel_cycles", 32'(n82), 32'd3);

        // Round robin with four continuously valid inputs.
        cycle(0, 1, 1);
        grants.delete();
        refill = 1; refill_len = 2;
        for (int n = 0; n < 4; n++) start(n, 2);
        repeat (20) cycle(1, 1, 1);
        refill = 0;
        repeat (16) cycle(1, 1, 1);
        check_eq("rr_ngrants", {31'd0, grants.size() >= 5}, 32'd1);
        if (grants.size() >= 5) begin
            check_eq("rr_g0", {24'd0, grants[0]}, 32'h80);
            check_eq("rr_g1", {24'd0, grants[1]}, 32'h81);
            check_eq("rr_g2", {24'd0, grants[2]}, 32'h82);
            check_eq("rr_g3", {24'd0, grants[3]}, 32'h83);
            check_eq("rr_g4", {24'd0, grants[4]}, 32'h80);
        end

        // Backpressure on input 1.
        start(1, 4);
        for (int i = 0; i < 12; i++) cycle(1, 1, (i % 2) == 0);
        check_eq("bp_err", {31'd0, err_oversize}, 32'd0);

        // Oversize packet on input 0: forced release after 4 beats.
        done0 = 0;
        start(0, 6);
        repeat (12) cycle(1, 1, 1);
        check_eq("ovs_err", {31'd0, err_oversize}, 32'd1);
        check_eq("ovs_done0", 32'(done0), 32'd2);

        // sched_en dropped during beat 2 of input 3's packet.
        start(3, 3);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        cycle(1, 0, 1);
        start(0, 2); start(1, 2);
        repeat (5) cycle(1, 0, 1);
        check_eq("en_hold_sel", {24'd0, bus_sel}, 32'h0);
        cycle(1, 1, 1);
        @(posedge clk); #1;
        check_eq("en_grant", {24'd0, bus_sel}, 32'h80);
        repeat (10) cycle(1, 1, 1);
        check_eq("en_err_sticky", {31'd0, err_oversize}, 32'd1);

        // Reset during beat 2 of input 1's packet.
        start(1, 4);
        cycle(1, 1, 1);
        cycle(1, 1, 1);
        start(3, 2);
        cycle(0, 1, 1);
        @(posedge clk); #1;
        check_eq("rst_sel", {24'd0, bus_sel}, 32'h0);
        check_eq("rst_err", {31'd0, err_oversize}, 32'd0);
        check_eq("rst_done", {31'd0, pkt_done}, 32'd0);
        grants.delete(); prev_sel = 8'd0;
        repeat (14) cycle(1, 1, 1);
        check_eq("rst_first_grant", (grants.size() > 0) ? {24'd0, grants[0]} : 32'hFFFF, 32'h81);

        // Random traffic, including oversize packets and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++)
                if (!act[n] && ($urandom % 4) == 0) start(n, 1 + int'($urandom % 6));
            cycle(($urandom % 300) != 0, ($urandom % 8) != 0, ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_rr_pkt_sched.md
Name: axis_rr_pkt_sched

Overview:
- Packet-level round-robin scheduler for four AXI-Stream FIFO outputs.
- Sits directly upstream of the 4:1 AXIS bus mux. It drives the mux's bus_sel code and returns tready to the selected FIFO.
- It locks one input from its first beat through its tlast beat, so packets are never interleaved on the muxed bus.

Parameters:
- SEL_BASE, 8'd128: base of the bus_sel grant code. Input n is selected by SEL_BASE+n; 8'd0 means nothing is selected.
- MAX_BEATS, 16'd1024: maximum beats allowed per packet before a forced release.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- sched_en  in  1  when low, no new grants are issued; a packet in progress still completes.
- axis_in_0_tvalid .. axis_in_3_tvalid  in  1 each  per-FIFO tvalid, also routed to the mux.
- axis_in_0_tlast .. axis_in_3_tlast  in  1 each  per-FIFO tlast, also routed to the mux.
- axis_out_tready  in  1  downstream ready for the muxed stream.
- axis_in_0_tready .. axis_in_3_tready  out  1 each  per-FIFO ready.
- bus_sel  out  8  mux select code (registered).
- pkt_done  out  1  one-cycle pulse, registered, asserted the cycle after a tlast beat or a forced release.
- pkt_src  out  2  index of the input whose packet just finished; valid while pkt_done=1.
- err_oversize  out  1  sticky flag, set by a forced release, cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clk edge), all registered state cleared:
  - state=IDLE, bus_sel=8'd0, grant=0, ptr=0, beat_cnt=0, pkt_done=0, pkt_src=0, err_oversize=0.
  - All tready outputs are 0 during and after reset until a grant is made.
- Reset mid-packet: the packet is abandoned with no pkt_done; after reset, arbitration restarts with ptr=0.
- Two states, IDLE and BUSY.
- IDLE:
  - bus_sel=0 and all tready=0.
  - If sched_en=1 and any tvalid=1, select the first valid input scanning ptr, ptr+1, ... mod 4.
  - At the next edge: state=BUSY, grant=idx, bus_sel=SEL_BASE+idx, beat_cnt=0.
  - Latency from tvalid rising in IDLE to bus_sel valid: 1 cycle. The first beat can transfer in that BUSY cycle.
  - If sched_en=0, or no tvalid is asserted, stay in IDLE.
- BUSY:
  - axis_in_<grant>_tready = axis_out_tready (combinational); all other tready=0.
  - Beat = granted tvalid & axis_out_tready. beat_cnt increments on each beat, is 16 bits wide, and is never allowed to wrap.
  - Beat with tlast=1 causes, at the next edge:
    - state=IDLE, bus_sel=0;
    - ptr = (grant+1) mod 4, wrapping from 3 to 0;
    - pkt_done=1, pkt_src=grant.
  - Forced release: a beat without tlast where beat_cnt == MAX_BEATS-1 triggers the same actions as a tlast beat, plus err_oversize=1. The remaining beats of that packet are presented later as a new packet.
  - tvalid low in BUSY: hold the grant indefinitely. There is no timeout on idle time.
  - sched_en falling in BUSY has no effect until the packet ends.
- Inter-packet gap: at least one IDLE cycle (bus_sel=0) between consecutive packets, even from the same input.
- Fairness: after input k finishes, input k is the lowest priority. Each of four continuously valid inputs is served once per four packets.
- Simultaneous events:
  - tlast beat together with other inputs' tvalid: the next grant is decided in the following IDLE cycle using the updated ptr.
  - An oversize beat that also carries tlast is treated as a normal tlast beat; err_oversize is not set.
- pkt_done is low in all cycles other than the one following a release.

Test Plan:
- Single input. Input 2 sends a 3-beat packet (tlast on beat 3) with axis_out_tready=1. Required: bus_sel=0x82 for 3 cycles starting 1 cycle after tvalid; axis_in_2_tready high for those 3 cycles; then bus_sel=0x00, pkt_done=1 and pkt_src=2 for 1 cycle.
- Round robin. All four inputs are continuously valid with 2-beat packets. Required: grant order 0,1,2,3,0; one bus_sel=0 cycle between packets; no tready ever asserted on a non-granted input.
- Backpressure. Input 1 sends a 4-beat packet while axis_out_tready toggles 1,0,1,0. Required: bus_sel holds at 0x81 throughout; axis_in_1_tready mirrors axis_out_tready; release occurs only after the 4th accepted beat.
- Oversize. MAX_BEATS=4; input 0 sends 6 beats with tlast on beat 6. Required: forced release after beat 4 with err_oversize=1 (sticky) and pkt_done=1; beats 5–6 are granted as a new packet after input 0's round-robin turn comes again.
- sched_en. sched_en is deasserted during beat 2 of a 3-beat packet on input 3. Required: the packet completes normally; bus_sel then stays 0 while inputs 0 and 1 are valid; after sched_en returns to 1, input 0 is granted next (ptr wrapped 3→0).
- Reset mid-packet. rst_n=0 for 1 cycle during beat 2 of input 1's packet. Required: the next cycle shows bus_sel=0, all tready=0, pkt_done=0, err_oversize=0; the first grant after reset goes to the lowest-index valid input.
